// File: rtl/dram_addr_demux.sv
// ---------------------------------------------------------------------------
// dram_addr_demux
//
// Bus monitor for a multiplexed-address DRAM interface. It watches the
// RAS/CAS/WE strobes and the shared row/column address lines and rebuilds
// the full linear address {row, column} of every column access. This
// includes page-mode accesses that reuse the open row. It also flags
// RAS-only refresh cycles and strobe protocol violations.
//
// Ports
//   clk            in   system clock, all inputs sampled on the rising edge
//   reset          in   synchronous active-high reset
//   ma             in   multiplexed address lines (MA_W bits)
//   ras_n          in   row address strobe, active low
//   cas_n          in   column address strobe, active low
//   we_n           in   write enable, active low, sampled with the CAS fall
//   addr           out  last rebuilt address {row, column} (2*MA_W bits)
//   addr_valid     out  one-cycle pulse, addr/wr just updated
//   wr             out  1 = last access was a write
//   refresh        out  one-cycle pulse, RAS-only refresh completed
//   refresh_count  out  16-bit wrapping count of RAS-only refreshes
//   err            out  one-cycle pulse, protocol violation
// ---------------------------------------------------------------------------
module dram_addr_demux #(
  parameter int MA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MA_W-1:0]   ma,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              we_n,
  output logic [2*MA_W-1:0] addr,
  output logic              addr_valid,
  output logic              wr,
  output logic              refresh,
  output logic [15:0]       refresh_count,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // RAS high
    S_ROW  = 2'd1,  // RAS low, no column yet in this row
    S_ACC  = 2'd2,  // RAS low, CAS low
    S_PAGE = 2'd3   // RAS low, CAS high, at least one column done
  } state_t;

  state_t              r_state;
  logic                r_ras_q;
  logic                r_cas_q;
  logic [MA_W-1:0]     r_row;
  logic [2*MA_W-1:0]   r_addr;
  logic                r_addr_valid;
  logic                r_wr;
  logic                r_refresh;
  logic [15:0]         r_refresh_count;
  logic                r_err;

  logic w_ras_fall;
  logic w_ras_rise;
  logic w_cas_fall;
  logic w_cas_rise;

  // Strobe history resets to 1, so a strobe already low when reset drops
  // is seen as a fresh fall.
  assign w_ras_fall = ~ras_n &  r_ras_q;
  assign w_ras_rise =  ras_n & ~r_ras_q;
  assign w_cas_fall = ~cas_n &  r_cas_q;
  assign w_cas_rise =  cas_n & ~r_cas_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_ras_q         <= 1'b1;
      r_cas_q         <= 1'b1;
      r_row           <= '0;
      r_addr          <= '0;
      r_addr_valid    <= 1'b0;
      r_wr            <= 1'b0;
      r_refresh       <= 1'b0;
      r_refresh_count <= '0;
      r_err           <= 1'b0;
    end else begin
      r_ras_q      <= ras_n;
      r_cas_q      <= cas_n;
      r_addr_valid <= 1'b0;
      r_refresh    <= 1'b0;
      r_err        <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_ras_fall) begin
            r_row   <= ma;
            r_state <= S_ROW;
          end
          // CAS before RAS (alone or in the same cycle) is never a
          // valid access, so no column is captured.
          if (w_cas_fall) begin
            r_err <= 1'b1;
          end
        end

        S_ROW: begin
          if (w_ras_rise) begin
            // A CAS fall racing the RAS rise makes the cycle ambiguous:
            // it is neither a refresh nor a column access.
            if (w_cas_fall) begin
              r_err <= 1'b1;
            end else begin
              r_refresh       <= 1'b1;
              r_refresh_count <= r_refresh_count + 16'd1;
            end
            r_state <= S_IDLE;
          end else if (w_cas_fall) begin
            r_addr       <= {r_row, ma};
            r_wr         <= ~we_n;
            r_addr_valid <= 1'b1;
            r_state      <= S_ACC;
          end
        end

        S_ACC: begin
          if (w_ras_rise) begin
            r_state <= S_IDLE;
          end else if (w_cas_rise) begin
            r_state <= S_PAGE;
          end
        end

        S_PAGE: begin
          if (w_ras_rise) begin
            r_state <= S_IDLE;
          end else if (w_cas_fall) begin
            r_addr       <= {r_row, ma};
            r_wr         <= ~we_n;
            r_addr_valid <= 1'b1;
            r_state      <= S_ACC;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr          = r_addr;
  assign addr_valid    = r_addr_valid;
  assign wr            = r_wr;
  assign refresh       = r_refresh;
  assign refresh_count = r_refresh_count;
  assign err           = r_err;

endmodule

// File: tb/tb_dram_addr_demux.sv
module tb_dram_addr_demux;

  localparam int MA_W = 8;

  logic              clk;
  logic              reset;
  logic [MA_W-1:0]   ma;
  logic              ras_n;
  logic              cas_n;
  logic              we_n;
  logic [2*MA_W-1:0] addr;
  logic              addr_valid;
  logic              wr;
  logic              refresh;
  logic [15:0]       refresh_count;
  logic              err;

  dram_addr_demux #(.MA_W(MA_W)) dut (
    .clk(clk), .reset(reset), .ma(ma), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .addr(addr), .addr_valid(addr_valid), .wr(wr),
    .refresh(refresh), .refresh_count(refresh_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: tracks whether a row is open, how many columns were
  // done in it and whether a CAS access is in progress.
  logic [15:0] m_addr;
  logic        m_wr, m_valid, m_ref, m_err;
  logic [15:0] m_cnt;
  logic [7:0]  m_row;
  bit          m_open, m_casin;
  int          m_ncols;
  logic        p_ras, p_cas;

  task automatic model_reset();
    m_addr = '0; m_wr = 0; m_valid = 0; m_ref = 0; m_err = 0; m_cnt = '0;
    m_row = '0; m_open = 0; m_casin = 0; m_ncols = 0; p_ras = 1; p_cas = 1;
  endtask

  task automatic model_edge(input logic rn, input logic cn, input logic wn,
                            input logic [7:0] a);
    bit rf, rr, cf, cr;
    rf = p_ras && !rn; rr = !p_ras && rn;
    cf = p_cas && !cn; cr = !p_cas && cn;
    m_valid = 0; m_ref = 0; m_err = 0;
    if (!m_open) begin
      if (rf) begin m_row = a; m_open = 1; m_ncols = 0; m_casin = 0; end
      if (cf) m_err = 1;
    end else if (rr) begin
      if (m_ncols == 0) begin
        if (cf) m_err = 1;
        else begin m_ref = 1; m_cnt = m_cnt + 16'd1; end
      end
      m_open = 0; m_casin = 0;
    end else if (m_casin) begin
      if (cr) m_casin = 0;
    end else if (cf) begin
      m_addr = {m_row, a}; m_wr = !wn; m_valid = 1;
      m_ncols++; m_casin = 1;
    end
    p_ras = rn; p_cas = cn;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("addr",          32'(addr),          32'(m_addr));
    check("wr",            32'(wr),            32'(m_wr));
    check("addr_valid",    32'(addr_valid),    32'(m_valid));
    check("refresh",       32'(refresh),       32'(m_ref));
    check("refresh_count", 32'(refresh_count), 32'(m_cnt));
    check("err",           32'(err),           32'(m_err));
  endtask

  // Inputs change at the falling edge, outputs are checked at the next
  // falling edge after the DUT's rising edge.
  task automatic step(input logic rn, input logic cn, input logic wn,
                      input logic [7:0] a);
    ras_n = rn; cas_n = cn; we_n = wn; ma = a;
    @(posedge clk);
    model_edge(rn, cn, wn, a);
    @(negedge clk);
    check_model();
  endtask

  task automatic rst_step(input logic rn, input logic cn);
    reset = 1'b1; ras_n = rn; cas_n = cn;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check_model();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1; ma = '0;
    model_reset();
    @(negedge clk);
    rst_step(1, 1);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_cnt",  32'(refresh_count), 32'h0);

    // Read
    step(0, 1, 1, 8'h12);
    step(0, 1, 1, 8'hFF);
    step(0, 0, 1, 8'h34);
    check("read_addr",  32'(addr), 32'h1234);
    check("read_wr",    32'(wr), 32'h0);
    check("read_valid", 32'(addr_valid), 32'h1);
    step(0, 0, 1, 8'h56);
    check("read_pulse_end", 32'(addr_valid), 32'h0);
    step(0, 1, 1, 8'h00);
    step(1, 1, 1, 8'h00);
    check("read_no_refresh", 32'(refresh), 32'h0);

    // Write then page mode
    step(0, 1, 1, 8'hA5);
    step(0, 0, 0, 8'h01);
    check("page1_addr", 32'(addr), 32'hA501);
    check("page1_wr",   32'(wr), 32'h1);
    step(0, 1, 1, 8'h00);
    step(0, 0, 1, 8'h02);
    check("page2_addr",  32'(addr), 32'hA502);
    check("page2_wr",    32'(wr), 32'h0);
    check("page2_valid", 32'(addr_valid), 32'h1);
    step(1, 1, 1, 8'h00);

    // RAS-only refresh
    rst_step(1, 1);
    for (int r = 0; r < 3; r++) begin
      step(0, 1, 1, 8'(r));
      step(1, 1, 1, 8'(r));
      check("refresh_pulse", 32'(refresh), 32'h1);
    end
    check("refresh_cnt",  32'(refresh_count), 32'd3);
    check("refresh_addr", 32'(addr), 32'h0);

    // CAS without RAS
    step(1, 0, 1, 8'h55);
    check("cbr_err",  32'(err), 32'h1);
    check("cbr_addr", 32'(addr), 32'h0);
    step(1, 1, 1, 8'h55);
    check("cbr_err_end", 32'(err), 32'h0);

    // RAS and CAS fall together
    step(0, 0, 1, 8'h77);
    check("sim_err",   32'(err), 32'h1);
    check("sim_valid", 32'(addr_valid), 32'h0);
    step(0, 1, 1, 8'h99);
    step(0, 0, 0, 8'h88);
    check("sim_next_addr", 32'(addr), 32'h7788);
    step(1, 1, 1, 8'h00);

    // Reset during an access, released with RAS still low
    step(0, 1, 1, 8'h11);
    step(0, 0, 1, 8'h22);
    rst_step(0, 1);
    check("mid_rst_addr",  32'(addr), 32'h0);
    check("mid_rst_valid", 32'(addr_valid), 32'h0);
    step(0, 1, 1, 8'h33);
    step(0, 0, 1, 8'h44);
    check("mid_rst_new", 32'(addr), 32'h3344);
    step(1, 1, 1, 8'h00);

    // RAS rise and CAS fall together in ROW
    step(0, 1, 1, 8'h09);
    step(1, 0, 1, 8'h01);
    check("coll_err", 32'(err), 32'h1);
    check("coll_cnt", 32'(refresh_count), 32'h0);
    check("coll_ref", 32'(refresh), 32'h0);
    step(1, 1, 1, 8'h00);

    // Randomized strobe traffic with occasional reset
    begin
      logic rn, cn;
      rn = 1; cn = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          rst_step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
        end else begin
          if ($urandom_range(0, 5) == 0) rn = ~rn;
          if ($urandom_range(0, 2) == 0) cn = ~cn;
          step(rn, cn, logic'($urandom_range(0, 1)), 8'($urandom));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
